rps_match_controller: RTL and testbench
=======================================

# rps_match_controller

Clocked match sequencer for the rock-paper-scissors game. It collects one locked choice per player, judges each round, and keeps both scores. It enforces a lock timeout and declares a match winner at a configurable score. It replaces ad-hoc per-strobe judging with a deterministic FSM, and its result and score outputs feed the existing seven-segment result and score decoders unchanged.

## Interface
Parameters:
- WIN_SCORE, 10: round wins needed to take the match; legal range 1..15.
- LOCK_TIMEOUT, 16: cycles allowed after the first lock before the round is forfeited; must be ≥1.
- REVEAL_CYCLES, 8: cycles the REVEAL state holds; must be ≥1.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- choice1  in  3  player-1 choice, one-hot {scissors,paper,rock}.
- choice2  in  3  player-2 choice, same encoding.
- lock1  in  1  player-1 lock strobe, level sampled each cycle.
- lock2  in  1  player-2 lock strobe.
- new_match  in  1  single-cycle request to clear scores and restart.
- result  out  2  last round outcome: 00 tie or none, 01 player 1, 10 player 2.
- score1  out  4  player-1 round wins.
- score2  out  4  player-2 round wins.
- locked1, locked2  out  1  the player's choice is latched for the current round.
- state  out  2  00 IDLE, 01 COLLECT, 10 REVEAL, 11 MATCH_OVER.
- round_done  out  1  one-cycle pulse when a round is judged.
- winner  out  2  match winner (01 or 10); 00 until MATCH_OVER.

## Operation
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All outputs 0.
  - Latched choices and timer cleared.
- IDLE → COLLECT unconditionally on the first clock edge after rst deasserts.
- COLLECT:
  - lockN=1 with unlocked player N and one-hot choiceN: latch choiceN and set lockedN.
  - A non-one-hot choice (000, 011, 111, …) is ignored; the player stays unlocked.
  - lockN while already locked is ignored, so a latched choice cannot change.
  - A simultaneous valid lock1 and lock2 latches both in the same cycle.
  - The timer starts at 0 on the cycle the first player locks and increments each cycle while exactly one player is locked.
- Judging, performed when both players are locked or the timer reaches LOCK_TIMEOUT-1 with one player locked:
  - rock beats scissors, paper beats rock, scissors beats paper.
  - Identical choices give result 00 and leave both scores unchanged.
  - On timeout the locked player wins the round.
  - The winner's score increments by 1.
  - Then go to REVEAL and pulse round_done.
- REVEAL:
  - Holds for REVEAL_CYCLES cycles; result and the scores are stable.
  - On exit, locked1/locked2 and the timer clear.
  - Next state is MATCH_OVER if either score equals WIN_SCORE, otherwise COLLECT.
  - Locks during REVEAL are ignored.
- MATCH_OVER:
  - winner is set to the player whose score equals WIN_SCORE.
  - Scores freeze and all locks are ignored.
- new_match, accepted in any state except IDLE:
  - Next cycle: score1=score2=0, result=00, winner=00, locks and timer cleared, state=COLLECT.
  - new_match takes priority over a judging event in the same cycle; that round is discarded and round_done does not pulse.
- Scores never exceed WIN_SCORE and never wrap.
- result holds its value until the next round is judged or new_match.

## Timing
- Lock latency: lockN sampled at edge k makes lockedN=1 after edge k.
- Judge latency:
  - When the second lock is sampled at edge k, result, scores, state=REVEAL and round_done=1 are all visible after edge k.
  - round_done drops after edge k+1.
- Timeout: a first lock at edge k, with no second lock, is judged at edge k+LOCK_TIMEOUT.
- REVEAL occupies exactly REVEAL_CYCLES cycles; the state change happens at the edge ending the last one.
- Asynchronous reset mid-round or mid-REVEAL clears everything immediately; no partial score update is retained.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Reset, then choice1=001 and choice2=100 locked in the same cycle → result=01, score1=1, round_done for 1 cycle, state=REVEAL for 8 cycles, then COLLECT with locks cleared.
- Tie: both players lock paper (010) → result=00, scores unchanged, round_done pulses.
- Timeout: only player 2 locks rock → 16 cycles later result=10, score2+1; a late lock1 during REVEAL is ignored.
- Invalid choice1=011 with lock1 → locked1 stays 0; a subsequent valid lock is accepted.
- Player 1 wins 10 rounds → MATCH_OVER with winner=01 and score1=10; further locks leave the scores unchanged; new_match → scores 0, state=COLLECT.
- new_match in the same cycle as the second lock, plus rst asserted mid-REVEAL → round discarded with no round_done; reset drives all outputs to 0 asynchronously.

Source files
------------

// File: rtl/rps_match_controller.sv
// rps_match_controller: rock-paper-scissors match FSM (lock collection, round judging, lock timeout, scoring, match winner)
//   clk, rst (async, active-low); choice1/choice2 one-hot {scissors,paper,rock}; lock1/lock2 lock strobes;
//   new_match clears scores and restarts; result 00 tie/none, 01 p1, 10 p2; score1/score2 round wins;
//   locked1/locked2 latched flags; state 00 IDLE 01 COLLECT 10 REVEAL 11 MATCH_OVER; round_done judge pulse; winner match winner
module rps_match_controller #(
    parameter int WIN_SCORE     = 10,
    parameter int LOCK_TIMEOUT  = 16,
    parameter int REVEAL_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] choice1,
    input  logic [2:0] choice2,
    input  logic       lock1,
    input  logic       lock2,
    input  logic       new_match,
    output logic [1:0] result,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       locked1,
    output logic       locked2,
    output logic [1:0] state,
    output logic       round_done,
    output logic [1:0] winner
);
    typedef enum logic [1:0] {IDLE, COLLECT, REVEAL, MATCH_OVER} state_t;
    localparam int TMAX = LOCK_TIMEOUT > REVEAL_CYCLES ? LOCK_TIMEOUT : REVEAL_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] R_LAST = TW'(REVEAL_CYCLES - 1);
    localparam logic [3:0] WS = 4'(WIN_SCORE);
    state_t st, st_n;
    logic [2:0] ch1, ch2, ch1_n, ch2_n, c1, c2;
    logic [TW-1:0] tmr, tmr_n;
    logic [1:0] result_n, winner_n;
    logic [3:0] score1_n, score2_n;
    logic locked1_n, locked2_n, round_done_n;
    logic acc1, acc2, l1, l2, both, tout, judge, p1w, p2w;
    assign state = st;
    assign acc1 = st == COLLECT && lock1 && !locked1 && $onehot(choice1);
    assign acc2 = st == COLLECT && lock2 && !locked2 && $onehot(choice2);
    assign l1 = locked1 | acc1;
    assign l2 = locked2 | acc2;
    assign c1 = acc1 ? choice1 : ch1;
    assign c2 = acc2 ? choice2 : ch2;
    assign both = l1 & l2;
    // the single timer doubles as the REVEAL counter; it is zeroed on judging
    assign tout = (locked1 ^ locked2) && tmr == T_LAST;
    assign judge = st == COLLECT && (both || tout);
    // X beats Y when X equals Y rotated left by one (rock>scissors, paper>rock, scissors>paper)
    assign p1w = both ? c1 == {c2[1:0], c2[2]} : l1;
    assign p2w = both ? c2 == {c1[1:0], c1[2]} : l2;
    always_comb begin
        st_n = st;
        ch1_n = ch1;
        ch2_n = ch2;
        tmr_n = tmr;
        locked1_n = locked1;
        locked2_n = locked2;
        result_n = result;
        score1_n = score1;
        score2_n = score2;
        round_done_n = 1'b0;
        winner_n = winner;
        case (st)
            IDLE: st_n = COLLECT;
            COLLECT: begin
                locked1_n = l1;
                locked2_n = l2;
                ch1_n = c1;
                ch2_n = c2;
                tmr_n = (locked1 ^ locked2) ? tmr + TW'(1) : tmr;
                if (judge) begin
                    st_n = REVEAL;
                    tmr_n = '0;
                    result_n = {p2w, p1w};
                    score1_n = (p1w && score1 != WS) ? score1 + 4'd1 : score1;
                    score2_n = (p2w && score2 != WS) ? score2 + 4'd1 : score2;
                    round_done_n = 1'b1;
                end
            end
            REVEAL: begin
                tmr_n = tmr + TW'(1);
                if (tmr == R_LAST) begin
                    tmr_n = '0;
                    locked1_n = 1'b0;
                    locked2_n = 1'b0;
                    ch1_n = '0;
                    ch2_n = '0;
                    st_n = (score1 == WS || score2 == WS) ? MATCH_OVER : COLLECT;
                    winner_n = score1 == WS ? 2'b01 : score2 == WS ? 2'b10 : 2'b00;
                end
            end
            MATCH_OVER: ;
        endcase
        if (new_match && st != IDLE) begin
            st_n = COLLECT;
            ch1_n = '0;
            ch2_n = '0;
            tmr_n = '0;
            locked1_n = 1'b0;
            locked2_n = 1'b0;
            result_n = 2'b00;
            score1_n = 4'd0;
            score2_n = 4'd0;
            round_done_n = 1'b0;
            winner_n = 2'b00;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st <= IDLE;
            ch1 <= '0;
            ch2 <= '0;
            tmr <= '0;
            locked1 <= 1'b0;
            locked2 <= 1'b0;
            result <= 2'b00;
            score1 <= 4'd0;
            score2 <= 4'd0;
            round_done <= 1'b0;
            winner <= 2'b00;
        end else begin
            st <= st_n;
            ch1 <= ch1_n;
            ch2 <= ch2_n;
            tmr <= tmr_n;
            locked1 <= locked1_n;
            locked2 <= locked2_n;
            result <= result_n;
            score1 <= score1_n;
            score2 <= score2_n;
            round_done <= round_done_n;
            winner <= winner_n;
        end
    end
endmodule

// File: tb/tb_rps_match_controller.sv
// tb_rps_match_controller: directed table-driven bench for rps_match_controller
module tb_rps_match_controller;
    logic clk, rst, lock1, lock2, new_match, locked1, locked2, round_done;
    logic [2:0] choice1, choice2;
    logic [1:0] result, state, winner;
    logic [3:0] score1, score2;
    int n_cmp = 0, n_err = 0;
    typedef struct {
        logic [2:0] c1, c2;
        logic [1:0] er;
        logic [3:0] s1, s2;
    } vec_t;
    vec_t tbl[7];
    rps_match_controller dut (
        .clk(clk), .rst(rst), .choice1(choice1), .choice2(choice2), .lock1(lock1), .lock2(lock2),
        .new_match(new_match), .result(result), .score1(score1), .score2(score2), .locked1(locked1),
        .locked2(locked2), .state(state), .round_done(round_done), .winner(winner)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic chk_all(input string nm, input logic [1:0] er, input logic [3:0] s1, input logic [3:0] s2,
                           input logic l1, input logic l2, input logic [1:0] st, input logic rd, input logic [1:0] w);
        chk({nm, ".result"}, 8'(result), 8'(er));
        chk({nm, ".score1"}, 8'(score1), 8'(s1));
        chk({nm, ".score2"}, 8'(score2), 8'(s2));
        chk({nm, ".locked1"}, 8'(locked1), 8'(l1));
        chk({nm, ".locked2"}, 8'(locked2), 8'(l2));
        chk({nm, ".state"}, 8'(state), 8'(st));
        chk({nm, ".round_done"}, 8'(round_done), 8'(rd));
        chk({nm, ".winner"}, 8'(winner), 8'(w));
    endtask
    task automatic play_round(input logic [2:0] c1, input logic [2:0] c2, input logic [1:0] er, input logic [3:0] s1,
                              input logic [3:0] s2, input logic [1:0] nst, input logic [1:0] w);
        choice1 = c1;
        choice2 = c2;
        lock1 = 1'b1;
        lock2 = 1'b1;
        step();
        lock1 = 1'b0;
        lock2 = 1'b0;
        chk_all("judge", er, s1, s2, 1'b1, 1'b1, 2'b10, 1'b1, 2'b00);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("reveal_state", 8'(state), 8'h2);
            if (i == 0) chk("round_done_drop", 8'(round_done), 8'h0);
        end
        step();
        chk_all("after_reveal", er, s1, s2, 1'b0, 1'b0, nst, 1'b0, w);
    endtask
    initial begin
        tbl[0] = '{3'b001, 3'b100, 2'b01, 4'd1, 4'd0};
        tbl[1] = '{3'b010, 3'b010, 2'b00, 4'd1, 4'd0};
        tbl[2] = '{3'b100, 3'b001, 2'b10, 4'd1, 4'd1};
        tbl[3] = '{3'b010, 3'b001, 2'b01, 4'd2, 4'd1};
        tbl[4] = '{3'b100, 3'b010, 2'b01, 4'd3, 4'd1};
        tbl[5] = '{3'b001, 3'b010, 2'b10, 4'd3, 4'd2};
        tbl[6] = '{3'b001, 3'b001, 2'b00, 4'd3, 4'd2};
        rst = 1'b0;
        choice1 = 3'b000;
        choice2 = 3'b000;
        lock1 = 1'b0;
        lock2 = 1'b0;
        new_match = 1'b0;
        step();
        step();
        chk_all("reset", 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
        rst = 1'b1;
        step();
        chk("idle_to_collect", 8'(state), 8'h1);
        for (int i = 0; i < 7; i++) play_round(tbl[i].c1, tbl[i].c2, tbl[i].er, tbl[i].s1, tbl[i].s2, 2'b01, 2'b00);
        choice2 = 3'b001;
        lock2 = 1'b1;
        step();
        lock2 = 1'b0;
        chk_all("single_lock", 2'b00, 4'd3, 4'd2, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00);
        repeat (15) step();
        chk("pre_timeout_state", 8'(state), 8'h1);
        step();
        chk_all("timeout", 2'b10, 4'd3, 4'd3, 1'b0, 1'b1, 2'b10, 1'b1, 2'b00);
        choice1 = 3'b001;
        lock1 = 1'b1;
        step();
        lock1 = 1'b0;
        chk("late_lock1", 8'(locked1), 8'h0);
        repeat (6) step();
        chk("timeout_reveal", 8'(state), 8'h2);
        step();
        chk_all("timeout_exit", 2'b10, 4'd3, 4'd3, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00);
        choice1 = 3'b011;
        lock1 = 1'b1;
        step();
        chk("invalid_choice", 8'(locked1), 8'h0);
        choice1 = 3'b010;
        step();
        chk("valid_relock", 8'(locked1), 8'h1);
        choice1 = 3'b100;
        choice2 = 3'b001;
        lock2 = 1'b1;
        step();
        lock1 = 1'b0;
        lock2 = 1'b0;
        chk_all("latched_kept", 2'b01, 4'd4, 4'd3, 1'b1, 1'b1, 2'b10, 1'b1, 2'b00);
        repeat (8) step();
        chk_all("latched_exit", 2'b01, 4'd4, 4'd3, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00);
        for (int s = 5; s <= 10; s++)
            play_round(3'b001, 3'b100, 2'b01, 4'(s), 4'd3, s == 10 ? 2'b11 : 2'b01, s == 10 ? 2'b01 : 2'b00);
        choice1 = 3'b001;
        choice2 = 3'b100;
        lock1 = 1'b1;
        lock2 = 1'b1;
        step();
        step();
        lock1 = 1'b0;
        lock2 = 1'b0;
        chk_all("over_locks", 2'b01, 4'd10, 4'd3, 1'b0, 1'b0, 2'b11, 1'b0, 2'b01);
        new_match = 1'b1;
        step();
        new_match = 1'b0;
        chk_all("new_match", 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00);
        choice1 = 3'b001;
        lock1 = 1'b1;
        step();
        lock1 = 1'b0;
        choice2 = 3'b100;
        lock2 = 1'b1;
        new_match = 1'b1;
        step();
        lock2 = 1'b0;
        new_match = 1'b0;
        chk_all("nm_priority", 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00);
        lock1 = 1'b1;
        lock2 = 1'b1;
        step();
        lock1 = 1'b0;
        lock2 = 1'b0;
        chk_all("pre_rst_judge", 2'b01, 4'd1, 4'd0, 1'b1, 1'b1, 2'b10, 1'b1, 2'b00);
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
        step();
        rst = 1'b1;
        step();
        chk_all("post_rst", 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
